uart_tx_arbiter: RTL and testbench

Round-robin arbiter that shares the single UART transmit path among `N_REQ` byte requesters. It sits between the requesting blocks and the `usart` write side: it drives `DATA_IN`/`n_WR` and monitors `Tx_RDY`. It issues exactly one byte per transmitter busy/idle cycle and returns a one-cycle grant to the requester whose byte was taken.

---
 rtl/uart_tx_arbiter.sv | 107 ++++++++++
 tb/tb_uart_tx_arbiter.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmit path among N_REQ byte
// requesters. One byte is issued per transmitter busy/idle cycle; the
// requester whose byte was taken gets a one-cycle grant pulse.
module uart_tx_arbiter #(
  parameter int N_REQ        = 4,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic               CLK50M,
  input  logic               n_RST,
  input  logic [N_REQ-1:0]   REQ,
  input  logic [8*N_REQ-1:0] REQ_DATA,
  output logic [N_REQ-1:0]   GNT,
  output logic [2:0]         GNT_ID,
  output logic [7:0]         TX_DATA,
  output logic               TX_WR,
  input  logic               TX_RDY,
  output logic               BUSY
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] WAIT_BUSY = 2'd1;
  localparam logic [1:0] WAIT_DONE = 2'd2;

  localparam int              CW       = $clog2(BUSY_TIMEOUT);
  localparam logic [CW-1:0]   CNT_LAST = CW'(BUSY_TIMEOUT - 1);
  localparam logic [2:0]      PTR_INIT = 3'(N_REQ - 1);

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [2:0]       ptr;
  logic [CW-1:0]    cnt;

  logic             win_found;
  logic [2:0]       win_idx;
  logic [7:0]       win_data;
  logic [N_REQ-1:0] win_onehot;

  // Round-robin pick: first pass covers indices above the pointer, second
  // pass wraps to indices at or below it, giving search order ptr+1 upward.
  always_comb begin
    win_found  = 1'b0;
    win_idx    = '0;
    win_data   = '0;
    win_onehot = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (!win_found && REQ[i] && (i > 32'(ptr))) begin
        win_found     = 1'b1;
        win_idx       = 3'(i);
        win_data      = REQ_DATA[8*i +: 8];
        win_onehot[i] = 1'b1;
      end
    end
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (!win_found && REQ[i] && (i <= 32'(ptr))) begin
        win_found     = 1'b1;
        win_idx       = 3'(i);
        win_data      = REQ_DATA[8*i +: 8];
        win_onehot[i] = 1'b1;
      end
    end
  end

  // Next-state decision; WAIT_BUSY exits on a visible busy or on timeout.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (TX_RDY && win_found)           state_nxt = WAIT_BUSY;
      WAIT_BUSY: if (!TX_RDY || (cnt == CNT_LAST))  state_nxt = WAIT_DONE;
      WAIT_DONE: if (TX_RDY)                        state_nxt = IDLE;
      default:                                      state_nxt = IDLE;
    endcase
  end

  // Registered state, pointer, timeout counter and all outputs.
  always_ff @(posedge CLK50M or negedge n_RST) begin
    if (!n_RST) begin
      state   <= IDLE;
      ptr     <= PTR_INIT;
      cnt     <= '0;
      GNT     <= '0;
      GNT_ID  <= '0;
      TX_DATA <= '0;
      TX_WR   <= 1'b0;
      BUSY    <= 1'b0;
    end else begin
      state <= state_nxt;
      BUSY  <= (state_nxt != IDLE);
      GNT   <= '0;
      TX_WR <= 1'b0;
      case (state)
        IDLE: begin
          if (state_nxt == WAIT_BUSY) begin
            TX_DATA <= win_data;
            GNT     <= win_onehot;
            GNT_ID  <= win_idx;
            TX_WR   <= 1'b1;
            ptr     <= win_idx;
            cnt     <= '0;
          end
        end
        WAIT_BUSY: cnt <= cnt + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed vector table, hand-written
// multi-cycle sequences, and a randomized run against a transaction-level model.
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int BT = 16;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   gnt;
  logic [2:0]     gnt_id;
  logic [7:0]     tx_data;
  logic           tx_wr;
  logic           tx_rdy;
  logic           busy;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.N_REQ(N), .BUSY_TIMEOUT(BT)) dut (
    .CLK50M   (clk),
    .n_RST    (rst_n),
    .REQ      (req),
    .REQ_DATA (req_data),
    .GNT      (gnt),
    .GNT_ID   (gnt_id),
    .TX_DATA  (tx_data),
    .TX_WR    (tx_wr),
    .TX_RDY   (tx_rdy),
    .BUSY     (busy)
  );

  typedef struct {
    logic [3:0]  req;
    logic [31:0] data;
    logic        rdy;
    logic [3:0]  gnt;
    logic        wr;
    logic [7:0]  txd;
    logic [2:0]  id;
    logic        busy;
  } vec_t;

  vec_t vecs[18];

  // reference model state: transaction view of one frame
  bit         m_in_frame;
  bit         m_busy_seen;
  int         m_age;
  int         m_last;
  logic [3:0] e_gnt;
  logic       e_wr;
  logic [7:0] e_txd;
  logic [2:0] e_id;
  logic       e_busy;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    req      = '0;
    req_data = '0;
    tx_rdy   = 1'b1;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic model_reset();
    m_in_frame  = 0;
    m_busy_seen = 0;
    m_age       = 0;
    m_last      = N - 1;
    e_gnt       = '0;
    e_wr        = 1'b0;
    e_txd       = '0;
    e_id        = '0;
    e_busy      = 1'b0;
  endtask

  // One clock edge of the arbiter's rules, computed from the inputs it sees.
  task automatic model_step(input logic [3:0] r, input logic [31:0] d, input logic rdy);
    int w;
    e_gnt = '0;
    e_wr  = 1'b0;
    if (!m_in_frame) begin
      if (rdy && (r != 4'd0)) begin
        w = -1;
        for (int k = 1; k <= N; k++) begin
          int c;
          c = (m_last + k) % N;
          if (w < 0 && ((r >> c) & 4'd1) != 4'd0) w = c;
        end
        e_gnt       = 4'(1 << w);
        e_wr        = 1'b1;
        e_txd       = 8'(d >> (8 * w));
        e_id        = 3'(w);
        m_last      = w;
        m_in_frame  = 1;
        m_age       = 0;
        m_busy_seen = 0;
      end
    end else if (!m_busy_seen) begin
      m_age++;
      if (!rdy || m_age == BT) m_busy_seen = 1;
    end else if (rdy) begin
      m_in_frame = 0;
    end
    e_busy = m_in_frame;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int         c;
    int         waited;
    logic [3:0] eg;
    logic [3:0] rq;
    logic [31:0] rd;
    logic       rdy;

    vecs[0]  = '{4'b0001, 32'h0000_00A5, 1'b1, 4'b0001, 1'b1, 8'hA5, 3'd0, 1'b1};
    vecs[1]  = '{4'b0000, 32'h0000_00A5, 1'b1, 4'b0000, 1'b0, 8'hA5, 3'd0, 1'b1};
    vecs[2]  = '{4'b0000, 32'h0000_00A5, 1'b0, 4'b0000, 1'b0, 8'hA5, 3'd0, 1'b1};
    vecs[3]  = '{4'b0000, 32'h0000_00A5, 1'b0, 4'b0000, 1'b0, 8'hA5, 3'd0, 1'b1};
    vecs[4]  = '{4'b0000, 32'h0000_00A5, 1'b0, 4'b0000, 1'b0, 8'hA5, 3'd0, 1'b1};
    vecs[5]  = '{4'b0000, 32'h0000_00A5, 1'b1, 4'b0000, 1'b0, 8'hA5, 3'd0, 1'b0};
    vecs[6]  = '{4'b1000, 32'h3C00_0000, 1'b0, 4'b0000, 1'b0, 8'hA5, 3'd0, 1'b0};
    vecs[7]  = '{4'b1000, 32'h3C00_0000, 1'b0, 4'b0000, 1'b0, 8'hA5, 3'd0, 1'b0};
    vecs[8]  = '{4'b1000, 32'h3C00_0000, 1'b1, 4'b1000, 1'b1, 8'h3C, 3'd3, 1'b1};
    vecs[9]  = '{4'b0000, 32'h3C00_0000, 1'b0, 4'b0000, 1'b0, 8'h3C, 3'd3, 1'b1};
    vecs[10] = '{4'b0000, 32'h3C00_0000, 1'b1, 4'b0000, 1'b0, 8'h3C, 3'd3, 1'b0};
    vecs[11] = '{4'b0011, 32'h0000_2221, 1'b1, 4'b0001, 1'b1, 8'h21, 3'd0, 1'b1};
    vecs[12] = '{4'b0010, 32'h0000_2221, 1'b0, 4'b0000, 1'b0, 8'h21, 3'd0, 1'b1};
    vecs[13] = '{4'b0010, 32'h0000_2221, 1'b1, 4'b0000, 1'b0, 8'h21, 3'd0, 1'b0};
    vecs[14] = '{4'b0010, 32'h0000_2221, 1'b1, 4'b0010, 1'b1, 8'h22, 3'd1, 1'b1};
    vecs[15] = '{4'b0011, 32'h0000_2221, 1'b0, 4'b0000, 1'b0, 8'h22, 3'd1, 1'b1};
    vecs[16] = '{4'b0011, 32'h0000_2221, 1'b1, 4'b0000, 1'b0, 8'h22, 3'd1, 1'b0};
    vecs[17] = '{4'b0011, 32'h0000_2221, 1'b1, 4'b0001, 1'b1, 8'h21, 3'd0, 1'b1};

    // reset values
    do_reset();
    check("rst_gnt",  32'(gnt),     32'd0);
    check("rst_wr",   32'(tx_wr),   32'd0);
    check("rst_txd",  32'(tx_data), 32'd0);
    check("rst_id",   32'(gnt_id),  32'd0);
    check("rst_busy", 32'(busy),    32'd0);

    // directed vector table
    for (int i = 0; i < 18; i++) begin
      req      = vecs[i].req;
      req_data = vecs[i].data;
      tx_rdy   = vecs[i].rdy;
      tick();
      check($sformatf("vec%0d_gnt", i),  32'(gnt),     32'(vecs[i].gnt));
      check($sformatf("vec%0d_wr", i),   32'(tx_wr),   32'(vecs[i].wr));
      check($sformatf("vec%0d_txd", i),  32'(tx_data), 32'(vecs[i].txd));
      check($sformatf("vec%0d_id", i),   32'(gnt_id),  32'(vecs[i].id));
      check($sformatf("vec%0d_busy", i), 32'(busy),    32'(vecs[i].busy));
    end

    // all four requesting, transmitter busy for 10 cycles per byte
    do_reset();
    req      = 4'b1111;
    req_data = 32'h1312_1110;
    tx_rdy   = 1'b1;
    for (int g = 0; g < 8; g++) begin
      waited = 0;
      tick();
      while (!tx_wr && waited < 50) begin
        tick();
        waited++;
      end
      eg = 4'b0001 << (g % 4);
      check($sformatf("a4_wr%0d", g),  32'(tx_wr),   32'd1);
      check($sformatf("a4_gnt%0d", g), 32'(gnt),     32'(eg));
      check($sformatf("a4_txd%0d", g), 32'(tx_data), 32'h10 + 32'(g % 4));
      check($sformatf("a4_id%0d", g),  32'(gnt_id),  32'(g % 4));
      tx_rdy = 1'b0;
      repeat (10) tick();
      tx_rdy = 1'b1;
    end

    // busy never seen: timeout path
    do_reset();
    req      = 4'b0001;
    req_data = 32'h0000_005A;
    tx_rdy   = 1'b1;
    tick();
    check("to_first_wr", 32'(tx_wr), 32'd1);
    c = 0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      c = k;
      if (k == 16) check("to_busy_at16", 32'(busy), 32'd1);
      if (k == 17) check("to_idle_at17", 32'(busy), 32'd0);
      if (tx_wr) break;
    end
    check("to_spacing", 32'(c), 32'd18);

    // reset during WAIT_DONE
    do_reset();
    req      = 4'b0100;
    req_data = 32'h0077_0000;
    tx_rdy   = 1'b1;
    tick();
    check("mr_gnt", 32'(gnt), 32'b0100);
    req    = 4'b0000;
    tx_rdy = 1'b0;
    tick();
    check("mr_busy", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mr_rst_outs", {gnt, tx_wr, tx_data, gnt_id, busy}, 32'd0);
    req      = 4'b1010;
    req_data = 32'h9900_5500;
    tx_rdy   = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("mr_no_wr%0d", k), 32'(tx_wr), 32'd0);
    end
    rst_n = 1'b1;
    tick();
    check("mr_post_gnt", 32'(gnt),     32'b0010);
    check("mr_post_id",  32'(gnt_id),  32'd1);
    check("mr_post_txd", 32'(tx_data), 32'h55);

    // randomized run against the reference model
    do_reset();
    model_reset();
    rq = '0;
    rd = '0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (!rq[i] && $urandom_range(0, 3) == 0) begin
          rq[i] = 1'b1;
          rd[8*i +: 8] = 8'($urandom);
        end
      end
      if ((cyc / 200) % 3 == 2) rdy = 1'b1;
      else rdy = ($urandom_range(0, 9) < 7);
      req      = rq;
      req_data = rd;
      tx_rdy   = rdy;
      model_step(rq, rd, rdy);
      tick();
      check($sformatf("rand%0d", cyc), {gnt, tx_wr, tx_data, gnt_id, busy},
            {e_gnt, e_wr, e_txd, e_id, e_busy});
      for (int i = 0; i < N; i++) begin
        if (e_gnt[i]) begin
          rq[i] = ($urandom_range(0, 1) == 1);
          if (rq[i]) rd[8*i +: 8] = 8'($urandom);
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
